// File: rtl/polyt1_pack_stream.sv
// Packs 256 signed coefficients as 10-bit t1 values into a 320-byte stream.
// The consumer side uses a valid/ready handshake.
module polyt1_pack_stream #(
    parameter int unsigned N       = 256,
    parameter int unsigned COEFF_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*COEFF_W-1:0] a_in,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned T1W    = 10;
    localparam int unsigned PackW  = N * T1W;
    localparam int unsigned NBytes = PackW / 8;
    localparam int unsigned CntW   = $clog2(NBytes);

    localparam logic [CntW-1:0] LastIdx = CntW'(NBytes - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [PackW-1:0] pack_q, pack_d;

    logic [PackW-1:0] load_vec;
    logic             range_bad;
    logic             xfer;

    // The byte layout is exactly the little-endian concatenation of the 10-bit
    // values, so packing is a plain concatenation of each coefficient's low bits.
    always_comb begin
        load_vec  = '0;
        range_bad = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            load_vec[T1W*i +: T1W] = a_in[COEFF_W*i +: T1W];
            // Any set bit above bit 9 means negative or above 1023.
            if (|a_in[COEFF_W*i + T1W +: COEFF_W - T1W]) begin
                range_bad = 1'b1;
            end
        end
    end

    assign xfer = (state_q == StEmit) && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pack_d  = pack_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                pack_d  = load_vec;
                cnt_d   = '0;
                err_d   = range_bad;
                state_d = StEmit;
            end
            StEmit: begin
                if (xfer) begin
                    // Current byte always sits in the low 8 bits of pack_q.
                    pack_d = {8'h00, pack_q[PackW-1:8]};
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Datapath needs no reset: it is only observed in EMIT, which follows a LOAD.
    always_ff @(posedge clock) begin
        pack_q <= pack_d;
    end

    always_comb begin
        out_valid = (state_q == StEmit);
        out_byte  = out_valid ? pack_q[7:0] : 8'h00;
        out_last  = out_valid && (cnt_q == LastIdx);
        busy      = (state_q == StLoad) || (state_q == StEmit);
        done      = (state_q == StDone);
        err       = err_q;
    end

endmodule
